// File: rtl/bsg_gateway_clk_seq.sv
// bsg_gateway_clk_seq: lock-gated sequencer for per-domain forwarded-clock enables and resets
// Ports:
//   clk_i        free-running sequencer clock
//   reset_i      synchronous active-high reset
//   locked_i     raw asynchronous PLL/DCM lock flags
//   chan_en_i    per-channel enable request
//   resequence_i one-cycle pulse forcing teardown and re-sequence
//   clk_en_o     ODDR2 D0 per channel (D1 tied low)
//   reset_o      per-channel synchronous reset, active-high
//   ready_o      high only in RUN
//   state_o      0 WAIT_LOCK, 1 STABLE, 2 RELEASE, 3 RUN
//   lost_cnt_o   saturating lock-loss count
module bsg_gateway_clk_seq #(
    parameter int num_chan_p = 4,
    parameter int num_lock_p = 2,
    parameter int lock_stable_cycles_p = 16,
    parameter int release_gap_p = 4,
    parameter int lost_cnt_width_p = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [num_lock_p-1:0]       locked_i,
    input  logic [num_chan_p-1:0]       chan_en_i,
    input  logic                        resequence_i,
    output logic [num_chan_p-1:0]       clk_en_o,
    output logic [num_chan_p-1:0]       reset_o,
    output logic                        ready_o,
    output logic [1:0]                  state_o,
    output logic [lost_cnt_width_p-1:0] lost_cnt_o
);
    localparam int iw = num_chan_p > 1 ? $clog2(num_chan_p) : 1;
    localparam int cw = $clog2(lock_stable_cycles_p + 1);
    localparam int gw = $clog2(release_gap_p + 1);
    typedef enum logic [1:0] {wait_lock_s, stable_s, release_s, run_s} state_e;
    state_e state, state_n;
    logic [num_lock_p-1:0] sync1, sync2;
    logic [cw-1:0] cnt, cnt_n;
    logic [gw-1:0] gap, gap_n;
    logic [iw-1:0] idx, idx_n;
    logic [num_chan_p-1:0] en_r, en_n, clk_en_n, rst_n;
    logic [lost_cnt_width_p-1:0] lost_n;
    logic all_locked, loss;
    assign all_locked = &sync2;
    assign loss = !all_locked && (state == release_s || state == run_s);
    assign ready_o = state == run_s;
    assign state_o = state;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        gap_n = gap;
        idx_n = idx;
        en_n = en_r;
        clk_en_n = clk_en_o;
        rst_n = reset_o;
        lost_n = lost_cnt_o;
        if (loss || resequence_i) begin
            state_n = wait_lock_s;
            cnt_n = '0;
            gap_n = '0;
            idx_n = '0;
            en_n = '0;
            clk_en_n = '0;
            rst_n = '1;
            lost_n = (loss && !(&lost_cnt_o)) ? lost_cnt_o + 1'b1 : lost_cnt_o;
        end else begin
            case (state)
                wait_lock_s: state_n = all_locked ? stable_s : wait_lock_s;
                stable_s: begin
                    if (!all_locked) begin
                        state_n = wait_lock_s;
                        cnt_n = '0;
                    end else if (cnt == cw'(lock_stable_cycles_p - 1)) begin
                        state_n = release_s;
                        cnt_n = '0;
                        gap_n = '0;
                        idx_n = '0;
                        en_n = chan_en_i;
                        clk_en_n[0] = chan_en_i[0];
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                release_s: begin
                    // disabled channels cost one cycle; enabled ones hold for the full gap
                    if (!en_r[idx] || gap == gw'(release_gap_p - 1)) begin
                        gap_n = '0;
                        rst_n[idx] = !en_r[idx];
                        if (idx == iw'(num_chan_p - 1)) begin
                            state_n = run_s;
                        end else begin
                            idx_n = idx + 1'b1;
                            clk_en_n[idx_n] = en_r[idx_n];
                        end
                    end else begin
                        gap_n = gap + 1'b1;
                    end
                end
                default: begin
                    en_n = en_r & chan_en_i;
                    clk_en_n = clk_en_o & chan_en_i;
                    rst_n = reset_o | ~chan_en_i;
                end
            endcase
        end
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1 <= '0;
            sync2 <= '0;
            state <= wait_lock_s;
            cnt <= '0;
            gap <= '0;
            idx <= '0;
            en_r <= '0;
            clk_en_o <= '0;
            reset_o <= '1;
            lost_cnt_o <= '0;
        end else begin
            sync1 <= locked_i;
            sync2 <= sync1;
            state <= state_n;
            cnt <= cnt_n;
            gap <= gap_n;
            idx <= idx_n;
            en_r <= en_n;
            clk_en_o <= clk_en_n;
            reset_o <= rst_n;
            lost_cnt_o <= lost_n;
        end
    end
endmodule

// File: tb/tb_bsg_gateway_clk_seq.sv
// tb_bsg_gateway_clk_seq: directed self-checking bench for the clock/reset sequencer
module tb_bsg_gateway_clk_seq;
    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic [1:0] locked_i = 2'b11;
    logic [3:0] chan_en_i = 4'hF;
    logic resequence_i = 1'b0;
    logic [3:0] clk_en_o, reset_o;
    logic ready_o;
    logic [1:0] state_o, lost_cnt_o;
    int checks = 0;
    int errors = 0;
    bsg_gateway_clk_seq #(.lost_cnt_width_p(2)) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .locked_i(locked_i),
        .chan_en_i(chan_en_i),
        .resequence_i(resequence_i),
        .clk_en_o(clk_en_o),
        .reset_o(reset_o),
        .ready_o(ready_o),
        .state_o(state_o),
        .lost_cnt_o(lost_cnt_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk_idle(input string tag, input logic [1:0] lost);
        chk({tag, " state"}, 32'(state_o), 0);
        chk({tag, " clk_en"}, 32'(clk_en_o), 0);
        chk({tag, " reset"}, 32'(reset_o), 32'hF);
        chk({tag, " ready"}, 32'(ready_o), 0);
        chk({tag, " lost"}, 32'(lost_cnt_o), 32'(lost));
    endtask
    task automatic do_reset();
        reset_i = 1'b1;
        tk(3);
        chk_idle("rst", 2'd0);
        reset_i = 1'b0;
    endtask
    initial begin
        // power-up sequence, all channels
        do_reset();
        tk(2);
        chk("t1 sync wait", 32'(state_o), 0);
        tk(1);
        chk("t1 stable", 32'(state_o), 1);
        tk(16);
        chk("t1 release", 32'(state_o), 2);
        chk("t1 clk_en0", 32'(clk_en_o), 32'h1);
        chk("t1 reset0 held", 32'(reset_o), 32'hF);
        tk(3);
        chk("t1 gap held", 32'(reset_o), 32'hF);
        tk(1);
        chk("t1 reset ch0", 32'(reset_o), 32'hE);
        chk("t1 clk_en ch1", 32'(clk_en_o), 32'h3);
        tk(4);
        chk("t1 reset ch1", 32'(reset_o), 32'hC);
        tk(4);
        chk("t1 reset ch2", 32'(reset_o), 32'h8);
        chk("t1 clk_en ch3", 32'(clk_en_o), 32'hF);
        tk(4);
        chk("t1 run", 32'(state_o), 3);
        chk("t1 reset all", 32'(reset_o), 0);
        chk("t1 ready", 32'(ready_o), 1);
        // lock loss in RUN: visible three edges later
        locked_i = 2'b10;
        tk(2);
        chk("t3 still run", 32'(state_o), 3);
        chk("t3 still out", 32'(reset_o), 0);
        tk(1);
        chk_idle("t3 torn", 2'd1);
        locked_i = 2'b11;
        tk(34);
        chk("t3 rerelease", 32'(state_o), 2);
        tk(1);
        chk("t3 rerun", 32'(state_o), 3);
        chk("t3 rerun reset", 32'(reset_o), 0);
        // glitch during STABLE
        do_reset();
        tk(13);
        chk("t2 stable", 32'(state_o), 1);
        locked_i = 2'b01;
        tk(1);
        locked_i = 2'b11;
        tk(1);
        chk("t2 pre drop", 32'(state_o), 1);
        tk(1);
        chk_idle("t2 drop", 2'd0);
        tk(1);
        chk("t2 restable", 32'(state_o), 1);
        tk(15);
        chk("t2 restart cnt", 32'(state_o), 1);
        tk(1);
        chk("t2 release", 32'(state_o), 2);
        // partial enable
        chan_en_i = 4'b0101;
        do_reset();
        tk(19);
        chk("t4 release", 32'(state_o), 2);
        chk("t4 clk_en0", 32'(clk_en_o), 32'h1);
        tk(4);
        chk("t4 reset ch0", 32'(reset_o), 32'hE);
        chk("t4 skip ch1 clk", 32'(clk_en_o), 32'h1);
        tk(1);
        chk("t4 clk_en ch2", 32'(clk_en_o), 32'h5);
        chk("t4 ch1 held", 32'(reset_o), 32'hE);
        tk(4);
        chk("t4 reset ch2", 32'(reset_o), 32'hA);
        chk("t4 still release", 32'(state_o), 2);
        tk(1);
        chk("t4 run", 32'(state_o), 3);
        chk("t4 run reset", 32'(reset_o), 32'hA);
        chk("t4 run clk_en", 32'(clk_en_o), 32'h5);
        // runtime disable, then resequence
        chan_en_i = 4'hF;
        do_reset();
        tk(35);
        chk("t5 run", 32'(state_o), 3);
        chan_en_i = 4'hB;
        tk(1);
        chk("t5 dis reset", 32'(reset_o), 32'h4);
        chk("t5 dis clk_en", 32'(clk_en_o), 32'hB);
        chan_en_i = 4'hF;
        tk(1);
        chk("t5 rise ignored", 32'(reset_o), 32'h4);
        chk("t5 rise ignored clk", 32'(clk_en_o), 32'hB);
        resequence_i = 1'b1;
        tk(1);
        resequence_i = 1'b0;
        chk_idle("t5 reseq", 2'd0);
        tk(1);
        chk("t5 stable", 32'(state_o), 1);
        tk(16);
        chk("t5 release", 32'(state_o), 2);
        tk(16);
        chk("t5 run", 32'(state_o), 3);
        chk("t5 ch2 back", 32'(reset_o), 0);
        chk("t5 clk back", 32'(clk_en_o), 32'hF);
        chk("t5 lost", 32'(lost_cnt_o), 0);
        // saturation, then reset mid-release
        do_reset();
        tk(19);
        chk("t6 release", 32'(state_o), 2);
        for (int i = 0; i < 5; i++) begin
            locked_i = 2'b10;
            tk(3);
            chk("t6 lost", 32'(lost_cnt_o), i < 2 ? i + 1 : 3);
            locked_i = 2'b11;
            tk(19);
            chk("t6 relrelease", 32'(state_o), 2);
        end
        reset_i = 1'b1;
        tk(1);
        chk_idle("t6 reset", 2'd0);
        reset_i = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
